// File: rtl/axi_read_master_pkg.sv
// Shared AXI3 read-channel widths, FSM state encodings and protocol constants
// for axi_read_master and its read-data FIFO.
package axi_read_master_pkg;

  localparam int ADD_ID_WIDTH = 4;
  localparam int ADD_WIDTH    = 32;
  localparam int BURST_LEN    = 4;
  localparam int BURST_SIZE   = 3;
  localparam int BURST_TYPE   = 2;
  localparam int DATA_WIDTH   = 128;
  localparam int RESP_WIDTH   = 2;

  localparam int AR_SIZE = $clog2(DATA_WIDTH / 8);

  localparam logic [BURST_TYPE-1:0] BURST_INCR = 2'b01;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_t;

endpackage

// File: rtl/axi_read_master_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module axi_rd_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_r;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_r == '0);
  assign full  = (count_r == FULL_CNT);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];
  assign count = count_r;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_read_master.sv
// AXI3 read initiator: splits one linear command into 4KB-safe INCR bursts and
// streams the data out through a FWFT FIFO. Optional macro: AXI_RD_RESP_CHECK_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ADDR  | AR payload presented once the FIFO can hold the whole burst
// ST_DATA  | accepting R beats of the current burst into the FIFO
// ST_DRAIN | all bursts received, waiting for the client to empty the FIFO
module axi_read_master
  import axi_read_master_pkg::*;
#(
  parameter logic [ADD_ID_WIDTH-1:0] RD_ID = '0,
  parameter int MAX_BURST  = 16,
  parameter int CMD_LEN_W  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADD_WIDTH-1:0]    cmd_addr,
  input  logic [CMD_LEN_W-1:0]    cmd_len,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    done,
  output logic                    err,
  output logic [ADD_ID_WIDTH-1:0] arid,
  output logic [ADD_WIDTH-1:0]    araddr,
  output logic [BURST_LEN-1:0]    arlen,
  output logic [BURST_SIZE-1:0]   arsize,
  output logic [BURST_TYPE-1:0]   arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ADD_ID_WIDTH-1:0] rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [RESP_WIDTH-1:0]   rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int BEATS_W = $clog2(MAX_BURST) + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  rd_state_t              state_r, state_nx;
  logic [ADD_WIDTH-1:0]   addr_r;
  logic [CMD_LEN_W-1:0]   remain_r;
  logic [BEATS_W-1:0]     burst_left_r;
  logic                   err_r;
  logic                   done_r;
  logic [12:0]            bound_4k;
  logic [CMD_LEN_W-1:0]   beats_full;
  logic [BEATS_W-1:0]     beats;
  logic                   fits;
  logic                   cmd_acc;
  logic                   ar_hs;
  logic                   push;
  logic                   pop;
  logic                   beat_final;
  logic                   drain_done;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [DATA_WIDTH:0]    fifo_dout;
  logic                   unused_ok;

  // Burst length limited by remaining beats, MAX_BURST and the next 4KB page.
  always_comb begin
    bound_4k   = (13'h1000 - {1'b0, addr_r[11:0]}) >> AR_SIZE;
    beats_full = CMD_LEN_W'(MAX_BURST);
    if (remain_r < beats_full) beats_full = remain_r;
    if (CMD_LEN_W'(bound_4k) < beats_full) beats_full = CMD_LEN_W'(bound_4k);
    beats = beats_full[BEATS_W-1:0];
  end

  assign fits       = (FIFO_DEPTH - int'(fifo_count)) >= int'(beats);
  assign cmd_acc    = (state_r == ST_IDLE) && cmd_valid;
  assign ar_hs      = arvalid && arready;
  assign push       = (state_r == ST_DATA) && rvalid;
  assign beat_final = push && (burst_left_r == BEATS_W'(1));
  assign pop        = !fifo_empty && out_ready;
  assign drain_done = fifo_empty || ((fifo_count == CNT_W'(1)) && out_ready);

  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:  if (cmd_acc && (cmd_len != '0)) state_nx = ST_ADDR;
      ST_ADDR:  if (ar_hs) state_nx = ST_DATA;
      ST_DATA:  if (beat_final) state_nx = (remain_r != '0) ? ST_ADDR : ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      remain_r     <= '0;
      burst_left_r <= '0;
      err_r        <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_nx;
      done_r  <= (cmd_acc && (cmd_len == '0)) || ((state_r == ST_DRAIN) && drain_done);
      if (cmd_acc) begin
        addr_r   <= {cmd_addr[ADD_WIDTH-1:AR_SIZE], {AR_SIZE{1'b0}}};
        remain_r <= cmd_len;
        err_r    <= 1'b0;
      end
      if (ar_hs) begin
        addr_r       <= addr_r + (ADD_WIDTH'(beats) << AR_SIZE);
        remain_r     <= remain_r - CMD_LEN_W'(beats);
        burst_left_r <= beats;
      end
      if (push) begin
        burst_left_r <= burst_left_r - BEATS_W'(1);
        // The beat counter drives the FSM; rlast only flags a disagreement.
        if (rlast != (burst_left_r == BEATS_W'(1))) err_r <= 1'b1;
`ifdef AXI_RD_RESP_CHECK_EN
        if ((rresp != RESP_OKAY) || (rid != RD_ID)) err_r <= 1'b1;
`endif
      end
    end
  end

`ifdef AXI_RD_RESP_CHECK_EN
  assign unused_ok = ^cmd_addr[AR_SIZE-1:0];
`else
  assign unused_ok = ^{cmd_addr[AR_SIZE-1:0], rid, rresp};
`endif

  axi_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({beat_final && (remain_r == '0), rdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready = (state_r == ST_IDLE);
  assign arvalid   = (state_r == ST_ADDR) && fits;
  assign rready    = (state_r == ST_DATA);
  assign arid      = RD_ID;
  assign araddr    = addr_r;
  assign arlen     = BURST_LEN'(beats - BEATS_W'(1));
  assign arsize    = BURST_SIZE'(AR_SIZE);
  assign arburst   = BURST_INCR;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout[DATA_WIDTH-1:0];
  assign out_last  = !fifo_empty && fifo_dout[DATA_WIDTH];
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master with a behavioural single-outstanding AXI3
// read slave whose data word equals the beat's byte address.
module tb_axi_read_master;
  import axi_read_master_pkg::*;

`ifdef AXI_RD_RESP_CHECK_EN
  localparam logic EXP_RESP_ERR = 1'b1;
`else
  localparam logic EXP_RESP_ERR = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [ADD_WIDTH-1:0]    cmd_addr = '0;
  logic [15:0]             cmd_len = '0;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    out_last;
  logic                    done;
  logic                    err;
  logic [ADD_ID_WIDTH-1:0] arid;
  logic [ADD_WIDTH-1:0]    araddr;
  logic [BURST_LEN-1:0]    arlen;
  logic [BURST_SIZE-1:0]   arsize;
  logic [BURST_TYPE-1:0]   arburst;
  logic                    arvalid;
  logic                    arready = 1'b1;
  logic [ADD_ID_WIDTH-1:0] rid = '0;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  always #5 clk = ~clk;

  axi_read_master #(
    .RD_ID      ('0),
    .MAX_BURST  (16),
    .CMD_LEN_W  (16),
    .FIFO_DEPTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done),
    .err       (err),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  int checks = 0;
  int errors = 0;
  int err_beat = -1;
  bit rlast_early = 1'b0;

  logic [31:0] s_addr;
  int          s_left;
  int          beat_no;
  logic [31:0] ar_addr_q[$];
  logic [3:0]  ar_len_q[$];
  logic [2:0]  ar_size_q[$];
  logic [1:0]  ar_burst_q[$];

  always @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= '0;
      s_addr = '0;
      s_left = 0;
      beat_no = 0;
      ar_addr_q.delete();
      ar_len_q.delete();
      ar_size_q.delete();
      ar_burst_q.delete();
    end else begin
      if (rvalid && rready) begin
        s_left--;
        s_addr += 32'd16;
        beat_no++;
      end
      if (arvalid && arready) begin
        ar_addr_q.push_back(araddr);
        ar_len_q.push_back(arlen);
        ar_size_q.push_back(arsize);
        ar_burst_q.push_back(arburst);
        s_addr = araddr;
        s_left = int'(arlen) + 1;
      end
      rvalid <= (s_left > 0);
      rdata  <= {96'h0, s_addr};
      rlast  <= (s_left == 1) || (rlast_early && (s_left == 2));
      rresp  <= (beat_no == err_beat) ? 2'b10 : 2'b00;
    end
  end

  int          cyc = 0;
  logic [31:0] out_q[$];
  logic        last_q[$];
  int          done_cnt;
  int          last_cyc;
  int          done_cyc;
  bit          arvalid_seen;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      out_q.delete();
      last_q.delete();
      done_cnt = 0;
      last_cyc = 0;
      done_cyc = 0;
      arvalid_seen = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_q.push_back(out_data[31:0]);
        last_q.push_back(out_last);
        if (out_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (arvalid) arvalid_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = n;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (done_cnt < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done_timeout"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic check_stream(input string tag, input int first, input logic [31:0] base, input int n);
    check({tag, " beat_count"}, 64'(out_q.size() - first), 64'(n));
    for (int j = 0; j < n; j++)
      check({tag, " beat"}, {31'h0, last_q[first+j], out_q[first+j]},
            {31'h0, (j == n - 1), base + 32'(16 * j)});
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [31:0] a, input logic [3:0] l);
    check({tag, " araddr"}, 64'(ar_addr_q[idx]), 64'(a));
    check({tag, " arlen"}, 64'(ar_len_q[idx]), 64'(l));
    check({tag, " arsize/arburst"}, {ar_size_q[idx], ar_burst_q[idx]}, {3'd4, 2'b01});
  endtask

  initial begin
    // Reset values
    do_reset();
    check("reset outputs", {arvalid, rready, out_valid, out_last, done, err, cmd_ready}, 7'b0000001);

    // 1: aligned 4-beat read
    out_ready = 1'b1;
    send_cmd(32'h1000, 16'd4);
    check("t1 arvalid latency", {arvalid, cmd_ready}, 2'b10);
    wait_done(1, 100, "t1");
    check("t1 ar count", 64'(ar_addr_q.size()), 64'd1);
    check_ar("t1 ar0", 0, 32'h1000, 4'd3);
    check_stream("t1", 0, 32'h1000, 4);
    check("t1 done after last", 64'(done_cyc - last_cyc), 64'd1);
    repeat (3) @(negedge clk);
    check("t1 done single pulse", 64'(done_cnt), 64'd1);
    check("t1 err", 64'(err), 64'd0);

    // 2: 4KB page split
    do_reset();
    send_cmd(32'h0FE0, 16'd4);
    wait_done(1, 100, "t2");
    check("t2 ar count", 64'(ar_addr_q.size()), 64'd2);
    check_ar("t2 ar0", 0, 32'h0FE0, 4'd1);
    check_ar("t2 ar1", 1, 32'h1000, 4'd1);
    check_stream("t2", 0, 32'h0FE0, 4);

    // 3: MAX_BURST split
    do_reset();
    send_cmd(32'h0, 16'd40);
    wait_done(1, 200, "t3");
    check("t3 ar count", 64'(ar_addr_q.size()), 64'd3);
    check_ar("t3 ar0", 0, 32'h000, 4'd15);
    check_ar("t3 ar1", 1, 32'h100, 4'd15);
    check_ar("t3 ar2", 2, 32'h200, 4'd7);
    check_stream("t3", 0, 32'h0, 40);

    // 4: client stalled, FIFO fills and throttles AR
    do_reset();
    out_ready = 1'b0;
    send_cmd(32'h0, 16'd40);
    repeat (40) @(negedge clk);
    check("t4 ar count in stall", 64'(ar_addr_q.size()), 64'd2);
    check("t4 arvalid held", 64'(arvalid), 64'd0);
    check("t4 nothing out in stall", 64'(out_q.size()), 64'd0);
    check("t4 out_valid in stall", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done(1, 300, "t4");
    check("t4 ar count", 64'(ar_addr_q.size()), 64'd3);
    check_ar("t4 ar2", 2, 32'h200, 4'd7);
    check_stream("t4", 0, 32'h0, 40);

    // 5: SLVERR on beat 2
    do_reset();
    err_beat = 1;
    send_cmd(32'h1000, 16'd4);
    wait_done(1, 100, "t5");
    err_beat = -1;
    check("t5 err", 64'(err), 64'(EXP_RESP_ERR));
    check_stream("t5", 0, 32'h1000, 4);

    // 7: early rlast flags err, counter still governs; err clears on next accept
    do_reset();
    rlast_early = 1'b1;
    send_cmd(32'h2000, 16'd4);
    wait_done(1, 100, "t7");
    rlast_early = 1'b0;
    check("t7 err early rlast", 64'(err), 64'd1);
    check_stream("t7", 0, 32'h2000, 4);
    send_cmd(32'h3000, 16'd4);
    wait_done(2, 100, "t7b");
    check("t7b err cleared", 64'(err), 64'd0);
    check_stream("t7b", 4, 32'h3000, 4);

    // 6: zero-length command, then reset while in DATA
    do_reset();
    send_cmd(32'h4000, 16'd0);
    wait_done(1, 20, "t6");
    repeat (3) @(negedge clk);
    check("t6 no arvalid", 64'(arvalid_seen), 64'd0);
    check("t6 done single pulse", 64'(done_cnt), 64'd1);
    send_cmd(32'h0, 16'd40);
    for (int n = 0; n < 20 && !rready; n++) @(negedge clk);
    check("t6 reached DATA", 64'(rready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6 reset in DATA", {arvalid, rready, out_valid, out_last, done, err, cmd_ready}, 7'b0000001);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
